imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes instruction memory and holds the processor in reset until the load is complete. It accepts a byte stream over a valid/ready handshake and packs it into 32-bit words. It drives the write port of a writable instruction memory, and releases its `cpu_reset` output only after the checksum verifies. It sits between an external byte source (host/UART receiver) and the `SingleCycle` top, gating that top's `reset`.

## Interface
- `ADDR_W`, 6, instruction-memory word-address width; depth = 2^ADDR_W words.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  source presents a byte.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle; a transfer occurs when `in_valid & in_ready`.
- `imem_we`  out  1  instruction-memory write strobe, one-cycle pulse.
- `imem_wa`  out  ADDR_W  instruction-memory word address.
- `imem_wd`  out  32  instruction word.
- `cpu_reset`  out  1  active-high reset to the processor top.
- `done`  out  1  load succeeded; sticky.
- `error`  out  1  load failed; sticky.

## Operation
- Stream format is `C`, then 4·(C+1) data bytes, then `K`:
  - `C` is one header byte; `C[ADDR_W-1:0]` = word count − 1, so 1..2^ADDR_W words.
  - Data words are big-endian: the first byte of each group goes to `imem_wd[31:24]`.
  - `K` is one checksum byte, equal to the XOR of all data bytes (header excluded).
- States:
  - HDR: wait for the header.
    - Header bits above `ADDR_W-1` nonzero → ERR.
    - Otherwise latch the count, clear the word address, byte index and checksum accumulator, then go to LOAD.
  - LOAD: each transfer shifts the byte into the packer and XORs it into the accumulator.
    - On the 4th byte of a word, register the write for the next cycle.
    - After the last byte of the last word → CHK.
  - CHK: the next transfer is compared with the accumulator.
    - Equal → DONE.
    - Unequal → ERR.
  - DONE: `done`=1, `cpu_reset`=0, `in_ready`=0. Terminal until reset.
  - ERR: `error`=1, `cpu_reset`=1, `in_ready`=0. Terminal until reset. Words already written remain in memory.
- `in_ready` = 1 in HDR, LOAD and CHK. The loader never back-pressures within these states.
- `in_valid` low stalls the FSM with no state change; gaps between bytes are unlimited.
- Word address increments by 1 after each write. It cannot wrap, because the count is bounded by the depth.
- `in_data` is ignored whenever no transfer occurs.

## Timing
- All outputs are registered, except `in_ready`, which decodes the state register.
- Reset values while `reset`=0 at a clock edge:
  - state HDR;
  - `imem_we`=0, `imem_wa`=0, `imem_wd`=0;
  - `done`=0, `error`=0;
  - `cpu_reset`=1.
- `in_ready` is forced to 0 while `reset`=0.
- Write latency: `imem_we` rises on the first edge after the 4th byte of a word transfers, and stays high exactly 1 cycle.
  - `imem_wa` and `imem_wd` are stable in that cycle.
  - `imem_wd` holds its value afterwards.
- Back-to-back words at one byte per cycle produce a write every 4 cycles; no data is lost.
- The final word's write and the CHK checksum comparison may occur in the same cycle; both must take effect.
- `cpu_reset` falls on the edge after the matching `K` transfers, in the same cycle `done` rises.
- `error` rises on the edge after the offending transfer.
- Reset asserted mid-load aborts immediately:
  - no further writes;
  - outputs go to their reset values;
  - the next stream starts at HDR.

## Structure
- The shared package `imem_loader_pkg` holds:
  - the state enum (HDR, LOAD, CHK, DONE, ERR);
  - the bytes-per-word constant (4);
  - the checksum seed constant (8'h00).
- One sub-module, `byte_packer`: a 4-byte big-endian shift register with a 2-bit index and a word-complete pulse. It has the same `clk`/`reset` convention.
- The FSM, address counter and checksum accumulator live in `imem_loader`.

## Test plan
- Header 8'h00, data 20 02 00 05, K=8'h27:
  - one write, `imem_wa`=0, `imem_wd`=32'h20020005;
  - `done`=1 and `cpu_reset`=0 one cycle after K.
- Header 8'h02, three words at one byte per cycle, correct K:
  - writes at addresses 0, 1, 2, spaced 4 cycles apart, with the correct data;
  - `done` asserts.
- Same stream with K XOR 8'h01:
  - three writes still occur;
  - `error`=1, `cpu_reset` stays 1, `in_ready`=0 afterwards.
- Header 8'hC0 (upper bits set, ADDR_W=6):
  - `error`=1 the next cycle;
  - no `imem_we` pulse.
- Header 8'h3F with 256 data bytes delivered under random `in_valid` gaps:
  - 64 writes to addresses 0..63 with no wrap;
  - correct K → `done`.
- Assert `reset`=0 after 6 data bytes:
  - one write issued, then `imem_we`=0 and state HDR;
  - a fresh 1-word stream loads correctly to address 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_LOAD = 3'd1,
        ST_CHK  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    // Bytes packed into one instruction word.
    localparam int BYTES_PER_WORD = 4;

    // Initial value of the running XOR checksum.
    localparam logic [7:0] CSUM_SEED = 8'h00;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: first byte of a group lands in word[31:24].
// Latency: combinational word/word_done on the 4th byte's shift cycle.
// Backpressure: none; shifts whenever shift_en is high.
//
// Ports:
//   clk, reset     clock, synchronous active-low reset
//   clr            restart packing at byte 0 (wins over shift_en)
//   shift_en       accept byte_in this cycle
//   byte_in        incoming stream byte
//   word_done      high in the cycle the 4th byte of a word is shifted in
//   word           assembled word, valid while word_done is high
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_done,
    output logic [31:0] word
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    // Only the first three bytes are stored; the fourth completes the word
    // straight from byte_in so the write can be registered on the same edge.
    logic [23:0]      hold_q, hold_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        hold_d = hold_q;
        idx_d  = idx_q;
        if (clr) begin
            hold_d = '0;
            idx_d  = '0;
        end else if (shift_en) begin
            hold_d = {hold_q[15:0], byte_in};
            idx_d  = idx_q + IDX_W'(1);
        end
    end

    assign word_done = shift_en && !clr && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    assign word      = {hold_q, byte_in};

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_q <= '0;
            idx_q  <= '0;
        end else begin
            hold_q <= hold_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header + big-endian words + XOR checksum into instruction memory; holds CPU in reset until verified.
// Latency: memory write and status outputs registered one edge after the relevant byte transfers.
// Backpressure: in_ready high in HDR/LOAD/CHK (never stalls the source there), low once DONE/ERR or in reset.
//
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   in_valid/in_data     byte stream from the host; in_ready accepts it
//   imem_we/wa/wd        instruction-memory write port (one-cycle strobe)
//   cpu_reset            active-high reset to the processor, released on success
//   done, error          sticky load status
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_wa,
    output logic [31:0]       imem_wd,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] last_q, last_d;     // index of the final word (header count)
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;     // next word address to be written
    logic [7:0]        csum_q, csum_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_wa_q, imem_wa_d;
    logic [31:0]       imem_wd_q, imem_wd_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer;
    logic [7:0]        hdr_hi;
    logic              pk_clr, pk_shift, pk_word_done;
    logic [31:0]       pk_word;

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr       (pk_clr),
        .shift_en  (pk_shift),
        .byte_in   (in_data),
        .word_done (pk_word_done),
        .word      (pk_word)
    );

    assign in_ready = reset && ((state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CHK));
    assign xfer     = in_valid && in_ready;
    // Header bits above the address width must be zero; a larger count cannot fit the memory.
    assign hdr_hi   = in_data >> ADDR_W;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        wcnt_d      = wcnt_q;
        csum_d      = csum_q;
        imem_we_d   = 1'b0;
        imem_wa_d   = imem_wa_q;
        imem_wd_d   = imem_wd_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;
        pk_clr      = 1'b0;
        pk_shift    = 1'b0;

        case (state_q)
            ST_HDR: begin
                if (xfer) begin
                    if (hdr_hi != 8'h00) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else begin
                        last_d    = in_data[ADDR_W-1:0];
                        wcnt_d    = '0;
                        imem_wa_d = '0;
                        csum_d    = CSUM_SEED;
                        pk_clr    = 1'b1;
                        state_d   = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    csum_d   = csum_q ^ in_data;
                    pk_shift = 1'b1;
                    if (pk_word_done) begin
                        imem_we_d = 1'b1;
                        imem_wa_d = wcnt_q;
                        imem_wd_d = pk_word;
                        // Wraps only after the last possible word, where it is never used again.
                        wcnt_d    = wcnt_q + ADDR_W'(1);
                        if (wcnt_q == last_q) begin
                            state_d = ST_CHK;
                        end
                    end
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    if (in_data == csum_q) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
                error_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_HDR;
            last_q      <= '0;
            wcnt_q      <= '0;
            csum_q      <= CSUM_SEED;
            imem_we_q   <= 1'b0;
            imem_wa_q   <= '0;
            imem_wd_q   <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            wcnt_q      <= wcnt_d;
            csum_q      <= csum_d;
            imem_we_q   <= imem_we_d;
            imem_wa_q   <= imem_wa_d;
            imem_wd_q   <= imem_wd_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign imem_we   = imem_we_q;
    assign imem_wa   = imem_wa_q;
    assign imem_wd   = imem_wd_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random byte streams, expected memory writes queued by a reference model.
// Latency: expected write visible in the cycle after its 4th byte transfers.
// Backpressure: source expects in_ready high for every byte it sends.
module tb_imem_loader;

    localparam int ADDR_W = 6;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        int                c;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_wa;
    logic [31:0]       imem_wd;
    logic              cpu_reset;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_wa   (imem_wa),
        .imem_wd   (imem_wd),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wr_t exp_q[$];
    int  n_pass  = 0;
    int  n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_wa), 32'(e.a));
                check("wr_data", imem_wd, e.d);
                check("wr_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    // Present one byte after an optional random gap; xc is the cycle stamp of its transfer edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap, output int xc);
        int gap;
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        check("in_ready_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        xc = cyc;
    endtask

    task automatic idle_input();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_wa", 32'(imem_wa), 32'd0);
        check("rst_wd", imem_wd, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Reference model: decode the stream by its rules and predict writes and final status.
    task automatic run_stream(input logic [7:0] hdr, input bq_t data, input logic [7:0] kx, input int max_gap);
        int         xc;
        int         nwords;
        logic [7:0] x;
        logic [31:0] w;
        wr_t        e;
        send_byte(hdr, max_gap, xc);
        if (hdr >= 8'(1 << ADDR_W)) begin
            idle_input();
            check("hdr_err_error", 32'(error), 32'd1);
            check("hdr_err_done", 32'(done), 32'd0);
            check("hdr_err_cpu_reset", 32'(cpu_reset), 32'd1);
            check("hdr_err_in_ready", 32'(in_ready), 32'd0);
            return;
        end
        nwords = int'(hdr) + 1;
        x = 8'h00;
        w = 32'h0;
        for (int j = 0; j < 4 * nwords; j++) begin
            send_byte(data[j], max_gap, xc);
            x = x ^ data[j];
            w = {w[23:0], data[j]};
            if (j % 4 == 3) begin
                e.a = ADDR_W'(j / 4);
                e.d = w;
                e.c = xc;
                exp_q.push_back(e);
            end
        end
        send_byte(x ^ kx, max_gap, xc);
        idle_input();
        check("end_done", 32'(done), (kx == 8'h00) ? 32'd1 : 32'd0);
        check("end_error", 32'(error), (kx == 8'h00) ? 32'd0 : 32'd1);
        check("end_cpu_reset", 32'(cpu_reset), (kx == 8'h00) ? 32'd0 : 32'd1);
        check("end_in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bq_t d;
        int  xc;
        wr_t e;
        logic [31:0] w;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        do_reset();

        // Single word with known checksum 8'h27.
        d = '{8'h20, 8'h02, 8'h00, 8'h05};
        run_stream(8'h00, d, 8'h00, 0);
        check("t1_wd_hold", imem_wd, 32'h20020005);
        check("t1_wa", 32'(imem_wa), 32'd0);

        // Three back-to-back words, good checksum, then same stream with corrupted checksum.
        do_reset();
        d = rand_bytes(12);
        run_stream(8'h02, d, 8'h00, 0);
        do_reset();
        run_stream(8'h02, d, 8'h01, 0);
        repeat (3) @(negedge clk);
        check("t3_error_sticky", 32'(error), 32'd1);
        check("t3_cpu_reset_held", 32'(cpu_reset), 32'd1);

        // Oversized header.
        do_reset();
        run_stream(8'hC0, d, 8'h00, 0);

        // Full memory with random source gaps.
        do_reset();
        d = rand_bytes(256);
        run_stream(8'h3F, d, 8'h00, 3);

        // Reset in the middle of a two-word load, then a fresh one-word stream.
        do_reset();
        d = rand_bytes(8);
        send_byte(8'h01, 0, xc);
        w = 32'h0;
        for (int j = 0; j < 6; j++) begin
            send_byte(d[j], 0, xc);
            w = {w[23:0], d[j]};
            if (j == 3) begin
                e.a = '0;
                e.d = w;
                e.c = xc;
                exp_q.push_back(e);
            end
        end
        do_reset();
        d = rand_bytes(4);
        run_stream(8'h00, d, 8'h00, 1);

        // A few random short streams with random checksum corruption.
        for (int t = 0; t < 4; t++) begin
            int n;
            logic [7:0] kx;
            do_reset();
            n  = $urandom_range(0, 5);
            kx = ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            d  = rand_bytes(4 * (n + 1));
            run_stream(8'(n), d, kx, 2);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
